// File: rtl/bcd_pkg.sv
// bcd_pkg: shared widths, limits and FSM state type for the BCD-to-binary
// conversion path.
//   BCD_DIGIT_W   : width of one BCD digit
//   BIN_W         : width of the binary result / accumulator
//   BCD_MAX_DIGIT : largest legal BCD digit value
//   NUM_DIGITS    : digits per conversion (thousands..ones)
//   IDX_W         : width of the digit index counter
package bcd_pkg;

  localparam int BCD_DIGIT_W   = 4;
  localparam int BIN_W         = 16;
  localparam int BCD_MAX_DIGIT = 9;
  localparam int NUM_DIGITS    = 4;
  localparam int IDX_W         = $clog2(NUM_DIGITS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  // True for any 4-bit code that is not a legal BCD digit (A..F).
  function automatic logic digit_invalid(input logic [BCD_DIGIT_W-1:0] d);
    return d > BCD_DIGIT_W'(BCD_MAX_DIGIT);
  endfunction

endpackage

// File: rtl/bcd_to_binary_if.sv
// bcd_to_binary_if: request/result bundle between digit-entry logic and the
// BCD-to-binary converter.
//   start            : conversion request (master -> slave)
//   Ths/Hds/Tens/Ones: BCD digits, captured on an accepted start
//   busy             : converter occupied (slave -> master)
//   done             : one-cycle result strobe
//   binary           : 16-bit result, held until the next done
//   err              : invalid-digit flag, held with binary
// Modports: master = digit source / result consumer, slave = converter.
interface bcd_to_binary_if;
  import bcd_pkg::*;

  logic                   start;
  logic [BCD_DIGIT_W-1:0] Ths;
  logic [BCD_DIGIT_W-1:0] Hds;
  logic [BCD_DIGIT_W-1:0] Tens;
  logic [BCD_DIGIT_W-1:0] Ones;
  logic                   busy;
  logic                   done;
  logic [BIN_W-1:0]       binary;
  logic                   err;

  modport master (
    output start, Ths, Hds, Tens, Ones,
    input  busy, done, binary, err
  );

  modport slave (
    input  start, Ths, Hds, Tens, Ones,
    output busy, done, binary, err
  );

endinterface

// File: rtl/bcd_mul10_add.sv
// bcd_mul10_add: combinational multiply-by-ten-and-add step used by
// MSD-first BCD-to-binary conversion.
//   acc_in  : running 16-bit accumulator
//   digit   : next 4-bit digit (not range-checked here)
//   acc_out : acc_in*10 + digit, modulo 2^16
// The multiply is done as (acc<<3)+(acc<<1) so no multiplier is inferred.
module bcd_mul10_add
  import bcd_pkg::*;
(
  input  logic [BIN_W-1:0]       acc_in,
  input  logic [BCD_DIGIT_W-1:0] digit,
  output logic [BIN_W-1:0]       acc_out
);

  logic [BIN_W-1:0] acc_x8;
  logic [BIN_W-1:0] acc_x2;

  assign acc_x8  = {acc_in[BIN_W-4:0], 3'b000};
  assign acc_x2  = {acc_in[BIN_W-2:0], 1'b0};
  assign acc_out = acc_x8 + acc_x2 + {{(BIN_W-BCD_DIGIT_W){1'b0}}, digit};

endmodule

// File: rtl/bcd_to_binary.sv
// bcd_to_binary: sequential four-digit BCD to 16-bit binary converter.
// A start seen in IDLE captures the digits; four CONV cycles then fold them
// in most significant first (acc = acc*10 + digit). The result and error flag
// are registered on the last CONV step, so done, binary and err all appear
// together in the DONE cycle, five cycles after the accepted start.
//   clk   : system clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : bcd_to_binary_if.slave (start, digits in; busy, done, binary, err out)
// Optional build macro BCD2BIN_DIGIT_CHECK_EN: digits > 9 raise err and force
// binary to zero. Without it raw digit codes are accumulated and err stays 0.
//
//   state | meaning
//   IDLE  | waiting for start; outputs hold last result
//   CONV  | one digit folded into acc per cycle, idx 3 -> 0
//   DONE  | done strobe cycle; start ignored; back to IDLE
module bcd_to_binary
  import bcd_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  bcd_to_binary_if.slave bus
);

  localparam int DIG_BUS_W = NUM_DIGITS * BCD_DIGIT_W;

  state_t                 state, state_nxt;
  logic [DIG_BUS_W-1:0]   digits, digits_nxt;
  logic [BIN_W-1:0]       acc, acc_nxt;
  logic [IDX_W-1:0]       idx, idx_nxt;
  logic                   busy_q, busy_nxt;
  logic                   done_q, done_nxt;
  logic [BIN_W-1:0]       binary_q, binary_nxt;
  logic                   err_q, err_nxt;
  logic [BCD_DIGIT_W-1:0] digit_cur;
  logic [BIN_W-1:0]       mac_out;

`ifdef BCD2BIN_DIGIT_CHECK_EN
  logic                   flag, flag_nxt;
`endif

  assign digit_cur = digits[idx*BCD_DIGIT_W +: BCD_DIGIT_W];

  bcd_mul10_add u_mul10_add (
    .acc_in  (acc),
    .digit   (digit_cur),
    .acc_out (mac_out)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      digits   <= '0;
      acc      <= '0;
      idx      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      binary_q <= '0;
      err_q    <= 1'b0;
`ifdef BCD2BIN_DIGIT_CHECK_EN
      flag     <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      digits   <= digits_nxt;
      acc      <= acc_nxt;
      idx      <= idx_nxt;
      busy_q   <= busy_nxt;
      done_q   <= done_nxt;
      binary_q <= binary_nxt;
      err_q    <= err_nxt;
`ifdef BCD2BIN_DIGIT_CHECK_EN
      flag     <= flag_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt  = state;
    digits_nxt = digits;
    acc_nxt    = acc;
    idx_nxt    = idx;
    busy_nxt   = busy_q;
    done_nxt   = 1'b0;
    binary_nxt = binary_q;
    err_nxt    = err_q;
`ifdef BCD2BIN_DIGIT_CHECK_EN
    flag_nxt   = flag;
`endif

    unique case (state)
      IDLE: begin
        if (bus.start) begin
          digits_nxt = {bus.Ths, bus.Hds, bus.Tens, bus.Ones};
          acc_nxt    = '0;
          idx_nxt    = IDX_W'(NUM_DIGITS - 1);
          busy_nxt   = 1'b1;
          state_nxt  = CONV;
`ifdef BCD2BIN_DIGIT_CHECK_EN
          flag_nxt   = 1'b0;
`endif
        end
      end

      CONV: begin
        acc_nxt = mac_out;
        idx_nxt = idx - 1'b1;
`ifdef BCD2BIN_DIGIT_CHECK_EN
        flag_nxt = flag | digit_invalid(digit_cur);
`endif
        // Result is registered on the final step so it lines up with done.
        if (idx == '0) begin
          state_nxt = DONE;
          done_nxt  = 1'b1;
`ifdef BCD2BIN_DIGIT_CHECK_EN
          binary_nxt = flag_nxt ? '0 : mac_out;
          err_nxt    = flag_nxt;
`else
          binary_nxt = mac_out;
          err_nxt    = 1'b0;
`endif
        end
      end

      DONE: begin
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end

      default: begin
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.binary = binary_q;
  assign bus.err    = err_q;

endmodule

// File: tb/tb_bcd_to_binary.sv
// tb_bcd_to_binary: self-checking bench for bcd_to_binary. Expected results
// come from plain decimal arithmetic on the digits; timing expectations come
// from the start->done relationship (busy k+1..k+5, done at k+5).
// Honors BCD2BIN_DIGIT_CHECK_EN the same way the design does.
module tb_bcd_to_binary;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_mis;

  // Model of the last delivered result (what binary/err must hold).
  logic [15:0] last_bin;
  logic        last_err;

  bcd_to_binary_if bus();

  bcd_to_binary dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit
  // after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model(input logic [3:0] t, h, te, o,
                       output logic [15:0] bin, output logic e);
    int v;
    v   = int'(t) * 1000 + int'(h) * 100 + int'(te) * 10 + int'(o);
    bin = 16'(v);
    e   = 1'b0;
`ifdef BCD2BIN_DIGIT_CHECK_EN
    if (t > 9 || h > 9 || te > 9 || o > 9) begin
      bin = 16'h0000;
      e   = 1'b1;
    end
`endif
  endtask

  // Full conversion from IDLE with start=0 on entry. With noise set, start
  // and the digits are scrambled while busy; none of it may have any effect.
  task automatic convert(input logic [3:0] t, h, te, o, input bit noise);
    logic [15:0] exp_bin;
    logic        exp_err;
    model(t, h, te, o, exp_bin, exp_err);
    bus.Ths = t; bus.Hds = h; bus.Tens = te; bus.Ones = o;
    bus.start = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (noise) begin
        bus.start = 1'($urandom);
        bus.Ths = 4'($urandom); bus.Hds = 4'($urandom);
        bus.Tens = 4'($urandom); bus.Ones = 4'($urandom);
      end else begin
        bus.start = 1'b0;
      end
      check_val("busy_during", {31'b0, bus.busy}, 32'd1);
      check_val("done_timing", {31'b0, bus.done}, (c == 5) ? 32'd1 : 32'd0);
      if (c < 5) begin
        check_val("binary_hold", {16'b0, bus.binary}, {16'b0, last_bin});
        check_val("err_hold", {31'b0, bus.err}, {31'b0, last_err});
      end else begin
        check_val("binary", {16'b0, bus.binary}, {16'b0, exp_bin});
        check_val("err", {31'b0, bus.err}, {31'b0, exp_err});
      end
    end
    bus.start = 1'b0;
    last_bin = exp_bin;
    last_err = exp_err;
    tick();
    check_val("busy_after", {31'b0, bus.busy}, 32'd0);
    check_val("done_after", {31'b0, bus.done}, 32'd0);
    check_val("binary_after", {16'b0, bus.binary}, {16'b0, last_bin});
  endtask

  task automatic check_quiet(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      tick();
      check_val({tag, "_done"}, {31'b0, bus.done}, 32'd0);
      check_val({tag, "_busy"}, {31'b0, bus.busy}, 32'd0);
    end
  endtask

  initial begin
    logic [3:0] d [4];
    n_cmp = 0;
    n_mis = 0;
    last_bin = 16'h0000;
    last_err = 1'b0;

    // Reset held two cycles with start asserted.
    rst_n = 1'b0;
    bus.start = 1'b1;
    bus.Ths = 4'd5; bus.Hds = 4'd5; bus.Tens = 4'd5; bus.Ones = 4'd5;
    tick();
    tick();
    check_val("rst_busy", {31'b0, bus.busy}, 32'd0);
    check_val("rst_done", {31'b0, bus.done}, 32'd0);
    check_val("rst_err", {31'b0, bus.err}, 32'd0);
    check_val("rst_binary", {16'b0, bus.binary}, 32'd0);
    rst_n = 1'b1;
    bus.start = 1'b0;
    check_quiet("post_rst", 3);

    // Directed values.
    convert(4'd1, 4'd2, 4'd3, 4'd4, 1'b0);
    check_val("val_1234", {16'b0, last_bin}, 32'h04D2);
    convert(4'd9, 4'd9, 4'd9, 4'd9, 1'b0);
    check_val("val_9999", {16'b0, last_bin}, 32'h270F);
    convert(4'd0, 4'd0, 4'd0, 4'd0, 1'b0);

    // start during busy (k+2) and in the DONE cycle (k+5) is ignored.
    bus.Ths = 4'd1; bus.Hds = 4'd2; bus.Tens = 4'd3; bus.Ones = 4'd4;
    bus.start = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      bus.start = (c == 2 || c == 5) ? 1'b1 : 1'b0;
      if (bus.start) begin
        bus.Ths = 4'd5; bus.Hds = 4'd5; bus.Tens = 4'd5; bus.Ones = 4'd5;
      end
      check_val("ign_done", {31'b0, bus.done}, (c == 5) ? 32'd1 : 32'd0);
    end
    check_val("ign_binary", {16'b0, bus.binary}, 32'h04D2);
    bus.start = 1'b0;
    last_bin = 16'h04D2;
    last_err = 1'b0;
    check_quiet("ign_no_second", 7);
    check_val("ign_binary_held", {16'b0, bus.binary}, 32'h04D2);

    // Non-BCD digit.
    convert(4'd1, 4'hA, 4'd0, 4'd0, 1'b0);
`ifdef BCD2BIN_DIGIT_CHECK_EN
    check_val("bad_digit_err", {31'b0, bus.err}, 32'd1);
    check_val("bad_digit_bin", {16'b0, bus.binary}, 32'h0000);
`else
    check_val("bad_digit_err", {31'b0, bus.err}, 32'd0);
    check_val("bad_digit_bin", {16'b0, bus.binary}, 32'h07D0);
`endif

    // Reset in the middle of a conversion.
    bus.Ths = 4'd7; bus.Hds = 4'd7; bus.Tens = 4'd7; bus.Ones = 4'd7;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    check_val("abort_busy", {31'b0, bus.busy}, 32'd0);
    check_val("abort_done", {31'b0, bus.done}, 32'd0);
    check_val("abort_err", {31'b0, bus.err}, 32'd0);
    check_val("abort_binary", {16'b0, bus.binary}, 32'd0);
    rst_n = 1'b1;
    last_bin = 16'h0000;
    last_err = 1'b0;
    check_quiet("abort_quiet", 6);
    convert(4'd0, 4'd0, 4'd4, 4'd2, 1'b0);
    check_val("val_0042", {16'b0, last_bin}, 32'h002A);

    // Back-to-back with start held high: one conversion every 6 cycles.
    bus.Ths = 4'd0; bus.Hds = 4'd1; bus.Tens = 4'd0; bus.Ones = 4'd0;
    bus.start = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      check_val("b2b_done", {31'b0, bus.done}, (c == 5 || c == 11) ? 32'd1 : 32'd0);
      check_val("b2b_busy", {31'b0, bus.busy}, (c == 6 || c == 12) ? 32'd0 : 32'd1);
    end
    bus.start = 1'b0;
    check_val("b2b_binary", {16'b0, bus.binary}, 32'd100);
    last_bin = 16'd100;
    last_err = 1'b0;
    tick();
    tick();

    // Randomized conversions: mostly legal digits, sometimes raw codes,
    // random idle gaps, random input noise while busy.
    for (int n = 0; n < 60; n++) begin
      for (int j = 0; j < 4; j++)
        d[j] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                           : 4'($urandom_range(0, 9));
      convert(d[0], d[1], d[2], d[3], 1'($urandom));
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        tick();
        check_val("gap_done", {31'b0, bus.done}, 32'd0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/bcd_to_binary.md
# bcd_to_binary

Sequential BCD-to-binary converter: accepts four BCD digits (thousands, hundreds, tens, ones) on a start pulse and produces the 16-bit unsigned binary value after a fixed multi-cycle multiply-accumulate. It is the inverse of the existing binary-to-BCD display path. It sits between digit-entry logic (keypad/switch digits, score or depth entry) and the game datapath, which consumes binary values.

## Interface
- No parameters; widths are fixed (4-bit digits, 16-bit result).
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  request a conversion; sampled only when `busy`=0.
- `Ths`  in  4  thousands digit; captured on accepted `start`.
- `Hds`  in  4  hundreds digit; captured on accepted `start`.
- `Tens`  in  4  tens digit; captured on accepted `start`.
- `Ones`  in  4  ones digit; captured on accepted `start`.
- `busy`  out  1  high from the cycle after an accepted `start` through the `done` cycle.
- `done`  out  1  single-cycle pulse; `binary`/`err` valid from this cycle.
- `binary`  out  16  result; held until the next `done`.
- `err`  out  1  invalid-digit flag; valid with `done`, held with `binary`.

## Operation
- Reset (`rst_n`=0 at a rising edge): state IDLE; `busy`=0, `done`=0, `err`=0, `binary`=16'h0000; digit registers, accumulator and index cleared.
- States: IDLE, CONV, DONE.
- IDLE: on `start`=1, capture {Ths,Hds,Tens,Ones} into a digit register, clear acc and err flag, set idx=3 (thousands), go to CONV. `start`=0 -> stay.
- CONV: acc <= acc*10 + digit[idx], with *10 computed as (acc<<3)+(acc<<1); idx decrements. After the idx=0 (ones) step, go to DONE. Exactly 4 CONV cycles, most significant digit first.
- DONE: `binary` <= acc, `err` <= sticky flag, `done`=1 for this cycle only; next state IDLE.
- Arithmetic: acc is 16 bits, unsigned. Valid BCD gives at most 9999 (14 bits); bits [15:14] are zero. Raw 4-bit digits give at most 15*1111 = 16665, which still fits 16 bits. No overflow is possible.
- `start` while `busy`=1, including the DONE cycle, is ignored and not queued.
- `start` held high continuously gives a new conversion every 6 cycles.
- Input digits may change freely after capture. Only the captured values are used.
- Reset mid-conversion aborts immediately. No `done` is produced, and outputs take their reset values.

## Timing
- `start` sampled high in cycle k (IDLE) -> `busy`=1 in cycles k+1..k+5, and `done`=1 in cycle k+5 only.
- Latency from start to done is 5 cycles. Minimum start-to-start period is 6 cycles.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- `BCD2BIN_DIGIT_CHECK_EN` defined:
  - Each digit is checked as it is consumed in CONV. Any digit > 9 sets the sticky flag.
  - In DONE, a set flag gives `err`=1 and `binary`=16'h0000.
- Not defined:
  - No check is made. Raw digit values are accumulated.
  - `err` is tied to 0; the port remains.

## Structure
- Package `bcd_pkg`:
  - `BCD_DIGIT_W`=4
  - `BIN_W`=16
  - `BCD_MAX_DIGIT`=9
  - `NUM_DIGITS`=4
  - state enum typedef {IDLE, CONV, DONE}
- One sub-module: `bcd_mul10_add`, combinational (acc_in[15:0], digit[3:0]) -> acc_in*10 + digit using shift-add. It is reusable by other BCD paths.
- FSM, digit register, idx counter and output registers live in `bcd_to_binary`.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles with `start`=1 -> `busy`=0, `done`=0, `err`=0, `binary`=0; no conversion starts.
- Digits 1,2,3,4, `start` pulse in cycle k -> `done`=1 only in k+5, `binary`=16'h04D2, `err`=0; `busy`=1 in k+1..k+5.
- Digits 9,9,9,9 -> `binary`=16'h270F; then digits 0,0,0,0 -> `binary`=16'h0000. The previous result holds until the second `done`.
- Start 1,2,3,4, then in cycles k+2 and k+5 drive `start`=1 with 5,5,5,5 -> one `done` with 16'h04D2, and no second conversion.
- Digits 1,A,0,0:
  - With `BCD2BIN_DIGIT_CHECK_EN` -> `err`=1, `binary`=0.
  - Without it -> `err`=0, `binary`=16'h07D0 (2000).
- Start 7,7,7,7, assert `rst_n`=0 in cycle k+2 -> all outputs reset next cycle, no `done`. A subsequent start 0,0,4,2 gives `binary`=16'h002A.
